// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU ops, branch/move conditions,
// condition-code reset value and the condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // cc layout is {ZF, SF, OF}
  localparam logic [2:0] CC_RESET = 3'b100;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    logic res;
    {zf, sf, of} = cc;
    case (fn)
      C_YES:   res = 1'b1;
      C_LE:    res = (sf ^ of) | zf;
      C_L:     res = sf ^ of;
      C_E:     res = zf;
      C_NE:    res = ~zf;
      C_GE:    res = ~(sf ^ of);
      C_G:     res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational Y86-64 ALU: add/sub/and/xor of aluB op aluA with ZF/SF/OF.
// Unsupported op codes return zero with no overflow.
module alu
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (result[WIDTH-1] != aluB[WIDTH-1]);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (result[WIDTH-1] != aluB[WIDTH-1]);
      end
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[WIDTH-1];

endmodule

// File: rtl/execute.sv
// Y86-64 SEQ execute stage: routes operands into the ALU per icode, holds the
// {ZF,SF,OF} condition-code register and evaluates Cnd for cmovXX/jXX.
module execute
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             stat_ok,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] valE,
  output logic             Cnd,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zf, alu_sf, alu_of;
  logic             cc_load;
  logic [2:0]       cc_q;

  // Every non-OPq instruction is folded into an add/sub so valE is always the ALU result.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (icode)
      I_RRMOVQ: alu_a = valA;
      I_IRMOVQ: alu_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC;
        alu_b = valB;
      end
      I_OPQ: begin
        alu_a  = valA;
        alu_b  = valB;
        alu_op = ifun;
      end
      I_CALL, I_PUSHQ: begin
        alu_a  = STACK_STEP;
        alu_b  = valB;
        alu_op = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = STACK_STEP;
        alu_b = valB;
      end
      default: begin
        alu_a = '0;
        alu_b = '0;
      end
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .aluA   (alu_a),
    .aluB   (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign valE = alu_result;

  assign cc_load = (icode == I_OPQ) && (ifun[3:2] == 2'b00) && stat_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (cc_load) begin
      cc_q <= {alu_zf, alu_sf, alu_of};
    end
  end

  assign cc = cc_q;

  always_comb begin
    Cnd = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      Cnd = cond_eval(ifun, cc_q);
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for execute: directed vector table, a back-to-back flag sequence and a
// randomized run against a behavioural model of the Y86-64 execute rules.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, ifun;
  logic        stat_ok;
  logic [63:0] valA, valB, valC;
  logic [63:0] valE;
  logic        Cnd;
  logic [2:0]  cc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .stat_ok(stat_ok),
    .valA(valA), .valB(valB), .valC(valC), .valE(valE), .Cnd(Cnd), .cc(cc)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        stat_ok;
    logic [63:0] a, b, c;
    logic [63:0] exp_vale;
    logic        exp_cnd;
    logic [2:0]  exp_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [3:0] ic, input logic [3:0] fn,
                     input logic ok, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c, input logic [63:0] ev, input logic ec,
                     input logic [2:0] ecc);
    vec_t v;
    v.name = n; v.rst = r; v.icode = ic; v.ifun = fn; v.stat_ok = ok;
    v.a = a; v.b = b; v.c = c; v.exp_vale = ev; v.exp_cnd = ec; v.exp_cc = ecc;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] ic, input logic [3:0] fn, input logic ok,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    rst = r; icode = ic; ifun = fn; stat_ok = ok; valA = a; valB = b; valC = c;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [2:0] m_cc;

  function automatic logic [63:0] m_vale(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    case (ic)
      4'h2:       return a;
      4'h3:       return c;
      4'h4, 4'h5: return b + c;
      4'h6: case (fn)
              4'h0: return b + a;
              4'h1: return b - a;
              4'h2: return b & a;
              4'h3: return b ^ a;
              default: return 64'd0;
            endcase
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  // Flags from signed-value reasoning rather than bit tests.
  function automatic logic [2:0] m_flags(input logic [3:0] fn, input logic [63:0] a,
                                         input logic [63:0] b);
    longint sa, sb, sr;
    logic z, s, o;
    sa = $signed(a); sb = $signed(b);
    sr = $signed(m_vale(4'h6, fn, a, b, 64'd0));
    z = (sr == 0);
    s = (sr < 0);
    o = 1'b0;
    if (fn == 4'h0) o = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
    if (fn == 4'h1) o = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
    return {z, s, o};
  endfunction

  function automatic logic m_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] f);
    logic lt;
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    lt = f[1] ^ f[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || f[2];
      4'd2: return lt;
      4'd3: return f[2];
      4'd4: return !f[2];
      4'd5: return !lt;
      4'd6: return !lt && !f[2];
      default: return 1'b0;
    endcase
  endfunction

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    drive(1'b1, 4'h1, 4'h0, 1'b1, 64'd0, 64'd0, 64'd0);

    //   name           rst icode ifun ok  valA      valB       valC     valE                  Cnd cc
    add("reset",        1, 4'h1, 4'h0, 1, 64'd0,    64'd0,     64'd0,   64'd0,                0, 3'b100);
    add("je_rst",       0, 4'h7, 4'h3, 1, 64'd0,    64'd0,     64'd0,   64'd0,                1, 3'b100);
    add("jne_rst",      0, 4'h7, 4'h4, 1, 64'd0,    64'd0,     64'd0,   64'd0,                0, 3'b100);
    add("add_ovf",      0, 4'h6, 4'h0, 1, MAXP,     MAXP,      64'd0,   64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b011);
    add("jl_ovf",       0, 4'h7, 4'h2, 1, 64'd0,    64'd0,     64'd0,   64'd0,                0, 3'b011);
    add("jg_ovf",       0, 4'h7, 4'h6, 1, 64'd0,    64'd0,     64'd0,   64'd0,                1, 3'b011);
    add("jle_ovf",      0, 4'h7, 4'h1, 1, 64'd0,    64'd0,     64'd0,   64'd0,                0, 3'b011);
    add("sub_zero",     0, 4'h6, 4'h1, 1, 64'd5,    64'd5,     64'd0,   64'd0,                0, 3'b100);
    add("sub_neg",      0, 4'h6, 4'h1, 1, 64'd5,    64'd3,     64'd0,   64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b010);
    add("jl_neg",       0, 4'h7, 4'h2, 1, 64'd0,    64'd0,     64'd0,   64'd0,                1, 3'b010);
    add("xor_statbad",  0, 4'h6, 4'h3, 0, 64'd1,    64'd1,     64'd0,   64'd0,                0, 3'b010);
    add("irmovq0",      0, 4'h3, 4'h0, 1, 64'd9,    64'd9,     64'd0,   64'd0,                0, 3'b010);
    add("opq_ifun7",    0, 4'h6, 4'h7, 1, 64'd1,    64'd2,     64'd0,   64'd0,                0, 3'b010);
    add("rmmovq",       0, 4'h4, 4'h0, 1, 64'd0,    64'd100,   64'd8,   64'd108,              0, 3'b010);
    add("mrmovq_neg",   0, 4'h5, 4'h0, 1, 64'd0,    64'h10,    ONES - 64'd7, 64'd8,           0, 3'b010);
    add("pushq",        0, 4'hA, 4'h0, 1, 64'd0,    64'd200,   64'd0,   64'd192,              0, 3'b010);
    add("popq",         0, 4'hB, 4'h0, 1, 64'd0,    64'd192,   64'd0,   64'd200,              0, 3'b010);
    add("pushq_wrap",   0, 4'hA, 4'h0, 1, 64'd0,    64'd0,     64'd0,   64'hFFFF_FFFF_FFFF_FFF8, 0, 3'b010);
    add("popq_wrap",    0, 4'hB, 4'h0, 1, 64'd0,    64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0,    0, 3'b010);
    add("call",         0, 4'h8, 4'h0, 1, 64'd0,    64'd8,     64'd0,   64'd0,                0, 3'b010);
    add("ret",          0, 4'h9, 4'h0, 1, 64'd0,    64'd8,     64'd0,   64'd16,               0, 3'b010);
    add("rst_vs_opq",   1, 4'h6, 4'h1, 1, 64'd2,    64'd1,     64'd0,   ONES,                 0, 3'b100);
    add("cmov_always",  0, 4'h2, 4'h0, 1, 64'h1234, 64'd7,     64'd0,   64'h1234,             1, 3'b100);
    add("and",          0, 4'h6, 4'h2, 1, 64'h3C,   64'hF0,    64'd0,   64'h30,               0, 3'b000);
    add("sub_ovf",      0, 4'h6, 4'h1, 1, 64'd1,    MINN,      64'd0,   MAXP,                 0, 3'b001);
    add("jl_of",        0, 4'h7, 4'h2, 1, 64'd0,    64'd0,     64'd0,   64'd0,                1, 3'b001);
    add("cmovge_of",    0, 4'h2, 4'h5, 1, 64'd4,    64'd0,     64'd0,   64'd4,                0, 3'b001);
    add("cmov_ifun7",   0, 4'h2, 4'h7, 1, 64'd5,    64'd0,     64'd0,   64'd5,                0, 3'b001);
    add("cmovne",       0, 4'h2, 4'h4, 1, 64'd6,    64'd0,     64'd0,   64'd6,                1, 3'b001);
    add("halt_cnd",     0, 4'h0, 4'h0, 1, 64'd1,    64'd2,     64'd3,   64'd0,                0, 3'b001);
    add("undef_icode",  0, 4'hD, 4'h0, 1, 64'd1,    64'd2,     64'd3,   64'd0,                0, 3'b001);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].icode, vecs[i].ifun, vecs[i].stat_ok,
            vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      check({vecs[i].name, ".valE"}, valE, vecs[i].exp_vale);
      check({vecs[i].name, ".Cnd"}, {63'd0, Cnd}, {63'd0, vecs[i].exp_cnd});
      @(posedge clk); #1;
      check({vecs[i].name, ".cc"}, {61'd0, cc}, {61'd0, vecs[i].exp_cc});
    end

    // Back-to-back: cmov before the OPq edge sees old flags, jXX after sees new.
    @(negedge clk);
    drive(1'b0, 4'h6, 4'h1, 1'b1, 64'd7, 64'd7, 64'd0);  // ZF=1 next
    #1;
    check("b2b.valE_pre", valE, 64'd0);
    @(posedge clk); #1;
    check("b2b.je_after", {63'd0, Cnd}, 64'd0);          // OPq itself: Cnd=0
    drive(1'b0, 4'h7, 4'h3, 1'b1, 64'd0, 64'd0, 64'd0);
    #1;
    check("b2b.je_new", {63'd0, Cnd}, 64'd1);
    drive(1'b0, 4'h2, 4'h6, 1'b1, 64'd11, 64'd0, 64'd0);
    #1;
    check("b2b.cmovg", {63'd0, Cnd}, 64'd0);
    check("b2b.cmov_valE", valE, 64'd11);

    // Randomized run against the model.
    m_cc = cc;
    for (int n = 0; n < 400; n++) begin
      logic        r, ok;
      logic [3:0]  ic, fn;
      logic [63:0] a, b, c;
      @(negedge clk);
      r  = ($urandom_range(0, 19) == 0);
      ok = ($urandom_range(0, 4) != 0);
      ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      c  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = b;
        1: begin a = MAXP; b = 64'($urandom_range(0, 3)); end
        2: begin b = MINN; a = 64'($urandom_range(0, 3)); end
        default: ;
      endcase
      drive(r, ic, fn, ok, a, b, c);
      #1;
      check("rnd.valE", valE, m_vale(ic, fn, a, b, c));
      check("rnd.Cnd", {63'd0, Cnd}, {63'd0, m_cnd(ic, fn, m_cc)});
      @(posedge clk);
      if (r) m_cc = 3'b100;
      else if (ic == 4'h6 && fn <= 4'h3 && ok) m_cc = m_flags(fn, a, b);
      #1;
      check("rnd.cc", {61'd0, cc}, {61'd0, m_cc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
